// File: rtl/memcache_key_packer.sv
// Packs a byte-serial memcache key into three little-endian 32-bit words plus length/overflow flag.
// One cycle from the accepted last byte to out_valid; input stalls (in_ready=0) while a key is presented.
module memcache_key_packer #(
   parameter int MAX_LEN = 12
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   input  logic        in_last,
   output logic        in_ready,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:0]  key_length,
   output logic [31:0] k0,
   output logic [31:0] k1,
   output logic [31:0] k2,
   output logic        key_err
);

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      DRAIN   = 2'd1,
      OUT     = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [95:0] key_q, key_d;
   logic        err_q, err_d;

   logic        byte_acc;
   logic [7:0]  cnt_inc;
   logic        at_max;
   logic [6:0]  bit_idx;

   // Handshake outputs are masked during reset so nothing transfers while RST is high.
   assign in_ready  = !RST && (state_q != OUT);
   assign out_valid = !RST && (state_q == OUT);

   assign byte_acc = in_valid && in_ready;
   assign cnt_inc  = (cnt_q == 8'hFF) ? 8'hFF : cnt_q + 8'd1;
   assign at_max   = ({1'b0, cnt_q} + 9'd1) == 9'(MAX_LEN);
   assign bit_idx  = {cnt_q[3:0], 3'b000};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      key_d   = key_q;
      err_d   = err_q;
      case (state_q)
         COLLECT: begin
            if (byte_acc) begin
               if (cnt_q < 8'(MAX_LEN)) begin
                  key_d[bit_idx +: 8] = in_data;
               end
               cnt_d = cnt_inc;
               if (in_last) begin
                  state_d = OUT;
                  err_d   = 1'b0;
               end else if (at_max) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            // Overflow bytes are only counted; the packed words keep the first MAX_LEN bytes.
            if (byte_acc) begin
               cnt_d = cnt_inc;
               if (in_last) begin
                  state_d = OUT;
                  err_d   = 1'b1;
               end
            end
         end
         OUT: begin
            if (out_ready) begin
               state_d = COLLECT;
               cnt_d   = 8'd0;
               key_d   = 96'd0;
               err_d   = 1'b0;
            end
         end
         default: begin
            state_d = COLLECT;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= COLLECT;
         cnt_q   <= 8'd0;
         key_q   <= 96'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         key_q   <= key_d;
         err_q   <= err_d;
      end
   end

   assign key_length = cnt_q;
   assign k0         = key_q[31:0];
   assign k1         = key_q[63:32];
   assign k2         = key_q[95:64];
   assign key_err    = err_q;

endmodule

// File: tb/tb_memcache_key_packer.sv
// Bench for memcache_key_packer: directed keys plus a randomized-gap run, checked against a packing model.
module tb_memcache_key_packer;

   localparam int ML = 12;

   logic        CLK = 1'b0;
   logic        RST;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_last;
   logic        in_ready;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  key_length;
   logic [31:0] k0, k1, k2;
   logic        key_err;

   memcache_key_packer #(.MAX_LEN(ML)) dut (
      .CLK(CLK), .RST(RST),
      .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
      .out_valid(out_valid), .out_ready(out_ready),
      .key_length(key_length), .k0(k0), .k1(k1), .k2(k2), .key_err(key_err)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [95:0] k;
      logic [7:0]  len;
      logic        err;
   } exp_t;

   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   int   nkeys    = 0;
   int   npushed  = 0;
   int   or_pct   = 100;
   bit   force_low = 1'b0;
   exp_t exp_q[$];
   logic [7:0] cur_key[$];

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, req);
      end
   endtask

   // Reference: byte i lands at bit 8*i of a flat 96-bit little-endian image, up to ML bytes.
   function automatic exp_t model();
      exp_t e;
      int   n;
      e = '0;
      n = cur_key.size();
      for (int i = 0; i < n && i < ML; i++) e.k[8*i +: 8] = cur_key[i];
      e.len = (n > 255) ? 8'd255 : 8'(n);
      e.err = (n > ML);
      return e;
   endfunction

   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge CLK); #1;
         out_ready = force_low ? 1'b0 : ($urandom_range(99) < or_pct);
      end
   end

   // Output checker: ordering, field values, stability under stall, and handshake exclusivity.
   initial begin
      exp_t held;
      bit   hold_vld;
      exp_t e;
      hold_vld = 0;
      held = '0;
      forever begin
         @(negedge CLK);
         if (RST) begin
            hold_vld = 0;
         end else if (out_valid) begin
            chk("ready_valid_exclusive", {127'd0, in_ready}, 128'd0);
            if (hold_vld)
               chk("stable_under_stall", {31'd0, k2, k1, k0, key_length, key_err}, {31'd0, held});
            if (out_ready) begin
               hold_vld = 0;
               nkeys++;
               if (exp_q.size() == 0) begin
                  chk("unexpected_key", {31'd0, k2, k1, k0, key_length, key_err}, 128'd0);
               end else begin
                  e = exp_q.pop_front();
                  chk("key_words", {32'd0, k2, k1, k0}, {32'd0, e.k});
                  chk("key_length", {120'd0, key_length}, {120'd0, e.len});
                  chk("key_err", {127'd0, key_err}, {127'd0, e.err});
               end
            end else begin
               held = {k2, k1, k0, key_length, key_err};
               hold_vld = 1;
            end
         end else if (hold_vld) begin
            chk("valid_dropped_without_handshake", 128'd0, 128'd1);
            hold_vld = 0;
         end
      end
   end

   task automatic send_byte(input logic [7:0] d, input logic last, input int gap);
      logic acc;
      int   w;
      while (gap > 0 && $urandom_range(99) < gap) begin
         in_valid = 1'b0;
         in_data  = 8'($urandom);
         in_last  = 1'($urandom);
         @(posedge CLK); #1;
      end
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      w = 0;
      forever begin
         @(negedge CLK);
         acc = in_ready;
         @(posedge CLK); #1;
         if (acc) break;
         w++;
         if (w > 2000) begin
            chk("in_ready_timeout", 128'd0, 128'd1);
            break;
         end
      end
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      in_last  = 1'($urandom);
   endtask

   task automatic send_key(input int gap, input bit push, input bit with_last);
      if (push) begin
         exp_q.push_back(model());
         npushed++;
      end
      for (int i = 0; i < cur_key.size(); i++)
         send_byte(cur_key[i], with_last && (i == cur_key.size() - 1), gap);
   endtask

   task automatic wait_in_ready();
      int w;
      w = 0;
      while (!in_ready) begin
         @(posedge CLK); #1;
         w++;
         if (w > 500) begin
            chk("idle_timeout", 128'd0, 128'd1);
            break;
         end
      end
   endtask

   task automatic pulse_reset();
      in_valid = 1'b0;
      RST = 1'b1;
      @(posedge CLK); #1;
      RST = 1'b0;
   endtask

   // Directed key with no gaps and out_ready high: checks 1-cycle latency and L+1 occupancy.
   task automatic directed_timed(input string nm);
      int   start;
      start = cyc;
      send_key(0, 1, 1);
      chk({nm, "_latency_out_valid"}, {127'd0, out_valid}, 128'd1);
      chk({nm, "_latency_in_ready"}, {127'd0, in_ready}, 128'd0);
      wait_in_ready();
      chk({nm, "_occupancy"}, 128'(cyc - start), 128'(cur_key.size() + 1));
   endtask

   task automatic load_str(input int n, input logic [7:0] first);
      cur_key.delete();
      for (int i = 0; i < n; i++) cur_key.push_back(first + 8'(i));
   endtask

   initial begin
      exp_t e;
      RST = 1'b1;
      in_valid = 1'b0;
      in_data = 8'd0;
      in_last = 1'b0;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      chk("out_valid_during_reset", {127'd0, out_valid}, 128'd0);
      @(posedge CLK); #1;
      RST = 1'b0;
      @(negedge CLK);
      chk("reset_state", {41'd0, in_ready, out_valid, k2, k1, k0, key_length, key_err},
          {41'd0, 1'b1, 1'b0, 96'd0, 8'd0, 1'b0});
      @(posedge CLK); #1;

      // "abcdefghijklm": one byte past MAX_LEN
      load_str(13, 8'h61);
      e = model();
      chk("model_034_words", {32'd0, e.k}, {32'd0, 32'h6C6B6A69, 32'h68676665, 32'h64636261});
      chk("model_034_len_err", {119'd0, e.len, e.err}, {119'd0, 8'd13, 1'b1});
      directed_timed("key13");

      // exactly MAX_LEN bytes, last on the boundary byte
      load_str(12, 8'h61);
      e = model();
      chk("model_035", {23'd0, e.k[95:64], e.len, e.err}, {23'd0, 32'h6C6B6A69, 8'd12, 1'b0});
      directed_timed("key12");

      // single byte held under a 5-cycle output stall
      cur_key.delete();
      cur_key.push_back(8'h41);
      e = model();
      chk("model_036", {31'd0, e.k, e.len, e.err}, {31'd0, 96'h41, 8'd1, 1'b0});
      force_low = 1'b1;
      @(posedge CLK); #1;
      send_key(0, 1, 1);
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         chk("stall_in_ready_low", {126'd0, in_ready, out_valid}, {126'd0, 2'b01});
         @(posedge CLK); #1;
      end
      force_low = 1'b0;
      wait_in_ready();

      // 300-byte key saturates the length
      cur_key.delete();
      for (int i = 0; i < 300; i++) cur_key.push_back(8'(i * 7 + 3));
      e = model();
      chk("model_037", {119'd0, e.len, e.err}, {119'd0, 8'd255, 1'b1});
      send_key(0, 1, 1);
      wait_in_ready();

      // reset mid-key in COLLECT discards the partial key
      load_str(5, 8'h70);
      send_key(0, 0, 0);
      pulse_reset();
      cur_key.delete();
      cur_key.push_back(8'h31);
      cur_key.push_back(8'h32);
      e = model();
      chk("model_038", {23'd0, e.k[31:0], e.len, e.err}, {23'd0, 32'h00003231, 8'd2, 1'b0});
      send_key(0, 1, 1);
      wait_in_ready();

      // reset in DRAIN, then reset while a finished key waits in OUT
      load_str(15, 8'h10);
      send_key(0, 0, 0);
      pulse_reset();
      force_low = 1'b1;
      load_str(3, 8'h20);
      send_key(0, 0, 1);
      @(posedge CLK); #1;
      pulse_reset();
      force_low = 1'b0;
      @(negedge CLK);
      chk("reset_from_out", {41'd0, in_ready, out_valid, k2, k1, k0, key_length, key_err},
          {41'd0, 1'b1, 1'b0, 96'd0, 8'd0, 1'b0});
      @(posedge CLK); #1;

      // random gaps on both sides
      or_pct = 60;
      for (int n = 0; n < 1000; n++) begin
         int len;
         len = $urandom_range(20, 1);
         cur_key.delete();
         for (int i = 0; i < len; i++) cur_key.push_back(8'($urandom));
         send_key(30, 1, 1);
      end

      for (int w = 0; w < 500 && exp_q.size() != 0; w++) begin
         @(posedge CLK); #1;
      end
      chk("all_keys_drained", 128'(exp_q.size()), 128'd0);
      chk("key_count", 128'(nkeys), 128'(npushed));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      failures++;
      $display("FAIL watchdog: simulation exceeded cycle budget at cycle %0d", cyc);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/memcache_key_packer.md
MEMCACHE_KEY_PACKER -- requirements
Module: memcache_key_packer

Interface
REQ-001 Parameter: MAX_LEN, default 12, maximum key bytes packed into k0..k2; legal range 1..12.
REQ-002 CLK  in  1  clock; all state updates on posedge CLK.
REQ-003 RST  in  1  reset, synchronous, active-high.
REQ-004 in_valid  in  1  key byte present on in_data.
REQ-005 in_data  in  8  key byte, stream order byte 0 first.
REQ-006 in_last  in  1  in_data is the final byte of the key; qualified by in_valid.
REQ-007 in_ready  out  1  packer accepts a byte this cycle.
REQ-008 out_valid  out  1  packed key presented on key_length/k0/k1/k2/key_err.
REQ-009 out_ready  in  1  hash pipeline consumes the packed key this cycle.
REQ-010 key_length  out  8  total bytes received for the key, saturating at 255.
REQ-011 k0, k1, k2  out  32 each  packed key words, bytes 0-3, 4-7 and 8-11.
REQ-012 key_err  out  1  key exceeded MAX_LEN; k0..k2 hold only the first MAX_LEN bytes.

Function
REQ-013 The block SHALL implement states COLLECT, DRAIN and OUT.
REQ-014 The block SHALL transfer a byte only on in_valid && in_ready, and a key only on out_valid && out_ready.
REQ-015 The block SHALL drive in_ready=1 in COLLECT and DRAIN, and in_ready=0 in OUT.
REQ-016 The block SHALL drive out_valid=1 only in OUT, so in_ready and out_valid are never both 1.
REQ-017 In COLLECT, byte number n (0-based count cnt) SHALL be written little-endian to word n/4, bits [8*(n%4)+7 : 8*(n%4)].
REQ-018 Key words SHALL be zero wherever no byte was written; with MAX_LEN < 12, bytes at index >= MAX_LEN SHALL remain zero.
REQ-019 The block SHALL increment cnt, width 8 and saturating at 255, on every accepted byte in COLLECT and DRAIN.
REQ-020 An accepted byte with in_last=1 in COLLECT SHALL cause a move to OUT, with key_length=cnt+1 and key_err=0.
REQ-021 An accepted byte with in_last=0 in COLLECT, when cnt+1 == MAX_LEN, SHALL cause a move to DRAIN.
REQ-022 In DRAIN, accepted bytes SHALL NOT alter k0..k2.
REQ-023 An accepted in_last byte in DRAIN SHALL cause a move to OUT with key_err=1 and key_length=min(total bytes, 255).
REQ-024 If the byte count reaches exactly MAX_LEN and that byte carries in_last, the block SHALL go to OUT with key_err=0, not to DRAIN.
REQ-025 In OUT, all output fields SHALL stay stable until out_ready=1.
REQ-026 On the OUT handshake, the block SHALL go to COLLECT and clear cnt, k0..k2 and key_err to 0 in the same edge.
REQ-027 Latency from the accepted in_last byte to out_valid=1 SHALL be one cycle.
REQ-028 After the OUT handshake, in_ready SHALL be 1 in the next cycle; back-to-back keys cost one idle input cycle.
REQ-029 With out_ready held at 1, a key of L bytes presented one byte per cycle SHALL occupy exactly L+1 cycles.
REQ-030 in_data and in_last SHALL be ignored whenever in_valid=0 or in_ready=0.

Reset
REQ-031 On RST=1 at posedge CLK, the block SHALL enter COLLECT with cnt=0, k0=k1=k2=0, key_length=0 and key_err=0.
REQ-032 While RST=1, out_valid SHALL be 0; in_ready SHALL be 1 from the first cycle after RST deasserts.
REQ-033 RST asserted mid-key, in any state, SHALL discard the partial key without emitting it; RST SHALL take priority over all handshakes.

Verification
REQ-034 Bytes 61 62 63 64 65 66 67 68 69 6A 6B 6C 6D ("abcdefghijklm") with last on 6D, MAX_LEN=12, out_ready=1 -> k0=64636261, k1=68676665, k2=6C6B6A69, key_length=13, key_err=1.
REQ-035 Bytes 61 62 63 64 65 66 67 68 69 6A 6B 6C with last on 6C -> k2=6C6B6A69, key_length=12, key_err=0, out_valid exactly one cycle after the last byte.
REQ-036 Single byte 41 with last -> k0=00000041, k1=k2=0, key_length=1; with out_ready held 0 for 5 cycles -> outputs stable and in_ready=0 throughout.
REQ-037 300-byte key -> key_length=255, key_err=1, k0..k2 equal to the first 12 bytes.
REQ-038 RST pulsed after 5 bytes of a key, then key 31 32 with last -> the only output is k0=00003231, key_length=2.
REQ-039 Random in_valid/out_ready gaps over 1000 keys of length 1..20 -> every output matches a reference packing model, with no lost or duplicated keys.
